// File: rtl/mem_port_arbiter.sv
// Shared memory bus port arbiter between the instruction fetch and data requesters.
// One transaction at a time; the winning request is latched and held until bus_ready.
module mem_port_arbiter #(
  parameter int         MAX_D_STREAK = 4,
  parameter logic [2:0] IFETCH_SIZE  = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        bus_valid,
  output logic        bus_is_write,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [63:0] bus_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        r_state, w_state_next;
  logic [SW-1:0] r_streak;
  logic [63:0]   r_addr, r_wdata;
  logic [2:0]    r_size;
  logic [7:0]    r_strobe;
  logic          w_grant_i, w_grant_d, w_streak_max;

  assign w_streak_max = (r_streak == SW'(MAX_D_STREAK));

  // Data normally wins (older instruction); a full streak lets a waiting fetch through.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dreq_valid && !(ireq_valid && w_streak_max)) begin
          w_grant_d    = 1'b1;
          w_state_next = BUSY_D;
        end else if (ireq_valid) begin
          w_grant_i    = 1'b1;
          w_state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_addr   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_d) begin
        r_addr   <= dreq_addr;
        r_size   <= dreq_size;
        r_strobe <= dreq_strobe;
        r_wdata  <= dreq_data;
        if (!ireq_valid)       r_streak <= '0;
        else if (!w_streak_max) r_streak <= r_streak + SW'(1);
      end else if (w_grant_i) begin
        r_addr   <= ireq_addr;
        r_size   <= IFETCH_SIZE;
        r_strobe <= '0;
        r_wdata  <= '0;
        r_streak <= '0;
      end
    end
  end

  assign bus_valid    = (r_state != IDLE);
  assign bus_is_write = |r_strobe;
  assign bus_addr     = r_addr;
  assign bus_size     = r_size;
  assign bus_strobe   = r_strobe;
  assign bus_wdata    = r_wdata;

  assign iresp_data_ok = (r_state == BUSY_I) && bus_ready;
  assign dresp_data_ok = (r_state == BUSY_D) && bus_ready;
  assign iresp_data    = iresp_data_ok ? bus_rdata : '0;
  assign dresp_data    = dresp_data_ok ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        ireq_valid = 1'b0, dreq_valid = 1'b0, bus_ready = 1'b0;
  logic [63:0] ireq_addr = '0, dreq_addr = '0, dreq_data = '0, bus_rdata = '0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic        iresp_data_ok, dresp_data_ok, bus_valid, bus_is_write;
  logic [63:0] iresp_data, dresp_data, bus_addr, bus_wdata;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;

  int n_cmp = 0, n_bad = 0;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .IFETCH_SIZE(3'b010)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .bus_valid(bus_valid), .bus_is_write(bus_is_write), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_strobe(bus_strobe), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, what was granted, how many data grants fetch has waited through.
  int          m_owner;  // 0 none, 1 fetch, 2 data
  int          m_streak;
  logic [63:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;

  task automatic model_step();
    if (reset) begin
      m_owner = 0; m_streak = 0; m_addr = '0; m_size = '0; m_strobe = '0; m_wdata = '0;
    end else if (m_owner == 0) begin
      if (dreq_valid && !(ireq_valid && m_streak == MAXS)) begin
        m_owner = 2; m_addr = dreq_addr; m_size = dreq_size;
        m_strobe = dreq_strobe; m_wdata = dreq_data;
        m_streak = ireq_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (ireq_valid) begin
        m_owner = 1; m_addr = ireq_addr; m_size = 3'd2; m_strobe = '0; m_wdata = '0;
        m_streak = 0;
      end
    end else if (bus_ready) begin
      m_owner = 0;
    end
  endtask

  initial begin
    string       exp_seq;
    byte         got_seq[10];
    int          n_grants;
    logic        e_iok, e_dok, prev_iok, prev_dok;

    // Reset state and single fetch
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    #1;
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_iok", iresp_data_ok, 0);
    chk("rst_dok", dresp_data_ok, 0);
    chk("rst_idata", iresp_data, 0);
    chk("rst_ddata", dresp_data, 0);
    chk("rst_bus_addr", bus_addr, 0);
    @(negedge clk); bus_ready = 1'b0; #1;
    chk("f_c1_valid", bus_valid, 1);
    chk("f_c1_size", bus_size, 2);
    chk("f_c1_strobe", bus_strobe, 0);
    chk("f_c1_addr", bus_addr, 64'h8000_0000);
    chk("f_c1_iok", iresp_data_ok, 0);
    @(negedge clk); bus_ready = 1'b1; bus_rdata = 64'h13; #1;
    chk("f_c2_valid", bus_valid, 1);
    chk("f_c2_iok", iresp_data_ok, 1);
    chk("f_c2_idata", iresp_data, 64'h13);
    chk("f_c2_dok", dresp_data_ok, 0);
    $display("fetch addr=%h data=%h", bus_addr, iresp_data);
    @(negedge clk); ireq_valid = 1'b0; bus_ready = 1'b0; #1;
    chk("f_c3_valid", bus_valid, 0);
    chk("f_c3_iok", iresp_data_ok, 0);

    // Simultaneous store and fetch: data first, one idle cycle, then fetch
    @(negedge clk);
    ireq_valid = 1'b1; ireq_addr = 64'h40;
    dreq_valid = 1'b1; dreq_addr = 64'h100; dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_data = 64'hDEAD;
    bus_ready = 1'b1; bus_rdata = 64'h55; #1;
    chk("sim_idle", bus_valid, 0);
    @(negedge clk); #1;
    chk("sim_d_write", bus_is_write, 1);
    chk("sim_d_wdata", bus_wdata, 64'hDEAD);
    chk("sim_d_addr", bus_addr, 64'h100);
    chk("sim_d_ok", dresp_data_ok, 1);
    chk("sim_d_iok", iresp_data_ok, 0);
    $display("store addr=%h wdata=%h", bus_addr, bus_wdata);
    @(negedge clk); dreq_valid = 1'b0; #1;
    chk("sim_gap", bus_valid, 0);
    @(negedge clk); #1;
    chk("sim_i_ok", iresp_data_ok, 1);
    chk("sim_i_addr", bus_addr, 64'h40);
    chk("sim_i_write", bus_is_write, 0);
    $display("fetch addr=%h data=%h", bus_addr, iresp_data);
    @(negedge clk); ireq_valid = 1'b0; bus_ready = 1'b0;

    // Starvation: both held high, bus always ready
    @(negedge clk);
    ireq_valid = 1'b1; dreq_valid = 1'b1; bus_ready = 1'b1;
    exp_seq = "DDDDIDDDDI";
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 10; c++) begin
      @(negedge clk); #1;
      if (bus_valid) begin
        got_seq[n_grants] = bus_is_write ? "D" : "I";
        $display("grant %0d: %s", n_grants, bus_is_write ? "D" : "I");
        n_grants++;
      end
    end
    chk("starve_count", n_grants, 10);
    for (int k = 0; k < n_grants; k++) chk($sformatf("starve_%0d", k), got_seq[k], exp_seq[k]);
    @(negedge clk); ireq_valid = 1'b0; dreq_valid = 1'b0; bus_ready = 1'b0;
    @(negedge clk); @(negedge clk);

    // Bus stall for 10 cycles with changing requester inputs
    dreq_valid = 1'b1; dreq_addr = 64'h200; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      ireq_addr = {$urandom, $urandom}; dreq_addr = {$urandom, $urandom}; dreq_strobe = 8'($urandom);
      #1;
      chk("stall_addr", bus_addr, 64'h200);
      chk("stall_strobe", bus_strobe, 0);
      chk("stall_dok", dresp_data_ok, 0);
      chk("stall_valid", bus_valid, 1);
      @(negedge clk);
    end
    bus_ready = 1'b1; bus_rdata = 64'hABC; #1;
    chk("stall_done_ok", dresp_data_ok, 1);
    chk("stall_done_data", dresp_data, 64'hABC);
    $display("load addr=%h data=%h", bus_addr, dresp_data);
    @(negedge clk); dreq_valid = 1'b0; bus_ready = 1'b0;

    // Reset in BUSY_D abandons the transaction
    @(negedge clk); dreq_valid = 1'b1; dreq_addr = 64'h300; dreq_strobe = 8'h0F;
    @(negedge clk); #1; chk("rb_busy", bus_valid, 1);
    @(negedge clk); reset = 1'b1; dreq_valid = 1'b0;
    @(negedge clk); reset = 1'b0; ireq_valid = 1'b1; ireq_addr = 64'h500; bus_ready = 1'b1; #1;
    chk("rb_valid", bus_valid, 0);
    chk("rb_dok", dresp_data_ok, 0);
    chk("rb_addr", bus_addr, 0);
    @(negedge clk); #1;
    chk("rb_fetch_ok", iresp_data_ok, 1);
    chk("rb_fetch_addr", bus_addr, 64'h500);
    chk("rb_fetch_dok", dresp_data_ok, 0);
    @(negedge clk); ireq_valid = 1'b0;

    // bus_ready while idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("idle_rdy_valid", bus_valid, 0);
      chk("idle_rdy_iok", iresp_data_ok, 0);
      chk("idle_rdy_dok", dresp_data_ok, 0);
    end

    // Randomized traffic against the model
    @(negedge clk); reset = 1'b1; bus_ready = 1'b0; #1; model_step();
    prev_iok = 1'b0; prev_dok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        ireq_valid = 1'b0; dreq_valid = 1'b0;
      end else begin
        if (prev_iok) ireq_valid = 1'($urandom_range(0, 1));
        else if (!ireq_valid) ireq_valid = ($urandom_range(0, 9) < 3);
        if (prev_dok) dreq_valid = 1'($urandom_range(0, 1));
        else if (!dreq_valid) dreq_valid = ($urandom_range(0, 9) < 3);
      end
      ireq_addr   = {$urandom, $urandom};
      dreq_addr   = {$urandom, $urandom};
      dreq_size   = 3'($urandom);
      dreq_strobe = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
      dreq_data   = {$urandom, $urandom};
      bus_ready   = ($urandom_range(0, 9) < 4);
      bus_rdata   = {$urandom, $urandom};
      #1;
      e_iok = (m_owner == 1) && bus_ready;
      e_dok = (m_owner == 2) && bus_ready;
      chk("r_valid", bus_valid, m_owner != 0);
      chk("r_addr", bus_addr, m_addr);
      chk("r_size", bus_size, m_size);
      chk("r_strobe", bus_strobe, m_strobe);
      chk("r_wdata", bus_wdata, m_wdata);
      chk("r_write", bus_is_write, m_strobe != 0);
      chk("r_iok", iresp_data_ok, e_iok);
      chk("r_dok", dresp_data_ok, e_dok);
      chk("r_idata", iresp_data, e_iok ? bus_rdata : 64'h0);
      chk("r_ddata", dresp_data, e_dok ? bus_rdata : 64'h0);
      if (e_iok || e_dok)
        $display("%s addr=%h rdata=%h", e_iok ? "fetch" : "data", m_addr, bus_rdata);
      prev_iok = e_iok && !reset;
      prev_dok = e_dok && !reset;
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
